// File: rtl/video_display_mode_filter.sv
// rtl/video_display_mode_filter.sv - host display-mode colour filter on the video path
//
// Accepts host display-mode requests and applies the chosen per-pixel colour
// mode through a two-stage registered pipeline. A requested mode is held as
// pending and only becomes active on a rising edge of vin_vs, so a frame never
// mixes modes. Sync and control signals travel through the same two stages.
//
// Optional feature macro: DISPLAY_MODE_DIM_EN (mode 3, dim = halve each channel).
// Without it a mode-3 request resolves to normal and no dim datapath is built.
//
// Ports:
//   clk, reset                      pixel clock, async active-high reset
//   notify_valid, notify_mode       host mode request (0 normal, 1 gray, 2 invert, 3 dim)
//   notify_done, affirm_mode        one-cycle acknowledge and the resolved mode
//   active_mode                     mode currently applied to pixels
//   vin_rgb/vs/hs/de/skip           incoming pixel {R,G,B} and controls
//   vout_rgb/vs/hs/de/skip          processed pixel and controls, 2 cycles later
module video_display_mode_filter #(
    parameter int COLOR_BITS         = 8,
    parameter int SUPPORTS_GRAYSCALE = 1,
    parameter int SUPPORTS_INVERT    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      notify_valid,
    input  logic [1:0]                notify_mode,
    output logic                      notify_done,
    output logic [1:0]                affirm_mode,
    output logic [1:0]                active_mode,
    input  logic [3*COLOR_BITS-1:0]   vin_rgb,
    input  logic                      vin_vs,
    input  logic                      vin_hs,
    input  logic                      vin_de,
    input  logic                      vin_skip,
    output logic [3*COLOR_BITS-1:0]   vout_rgb,
    output logic                      vout_vs,
    output logic                      vout_hs,
    output logic                      vout_de,
    output logic                      vout_skip
);

    localparam int W   = 3 * COLOR_BITS;
    localparam int ACC = COLOR_BITS + 8;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_GRAY   = 2'd1;
    localparam logic [1:0] MODE_INVERT = 2'd2;
    localparam logic [1:0] MODE_DIM    = 2'd3;

    logic [1:0]  pending_mode;
    logic [1:0]  resolved_mode;
    logic        prev_vs;
    logic        vs_rise;

    logic [W-1:0] s1_rgb;
    logic         s1_vs, s1_hs, s1_de, s1_skip;
    logic [1:0]   s1_mode;

    logic [COLOR_BITS-1:0] s1_r, s1_g, s1_b;
    logic [ACC-1:0]        luma_acc;
    logic [COLOR_BITS-1:0] luma;
    logic [W-1:0]          s2_next;

    // Modes the build does not support fall back to normal.
    always_comb begin
        resolved_mode = MODE_NORMAL;
        case (notify_mode)
            MODE_GRAY:   resolved_mode = (SUPPORTS_GRAYSCALE != 0) ? MODE_GRAY : MODE_NORMAL;
            MODE_INVERT: resolved_mode = (SUPPORTS_INVERT != 0) ? MODE_INVERT : MODE_NORMAL;
`ifdef DISPLAY_MODE_DIM_EN
            MODE_DIM:    resolved_mode = MODE_DIM;
`endif
            default:     resolved_mode = MODE_NORMAL;
        endcase
    end

    assign vs_rise = vin_vs & ~prev_vs;

    // Request handling and frame-boundary mode switch. On a coincident request
    // and vs rise, active_mode takes the old pending_mode (nonblocking read).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            notify_done  <= 1'b0;
            affirm_mode  <= MODE_NORMAL;
            pending_mode <= MODE_NORMAL;
            active_mode  <= MODE_NORMAL;
            prev_vs      <= 1'b0;
        end else begin
            notify_done <= notify_valid;
            if (notify_valid) begin
                pending_mode <= resolved_mode;
                affirm_mode  <= resolved_mode;
            end
            if (vs_rise) begin
                active_mode <= pending_mode;
            end
            prev_vs <= vin_vs;
        end
    end

    // Stage 1: capture inputs and the mode in effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_rgb  <= '0;
            s1_vs   <= 1'b0;
            s1_hs   <= 1'b0;
            s1_de   <= 1'b0;
            s1_skip <= 1'b0;
            s1_mode <= MODE_NORMAL;
        end else begin
            s1_rgb  <= vin_rgb;
            s1_vs   <= vin_vs;
            s1_hs   <= vin_hs;
            s1_de   <= vin_de;
            s1_skip <= vin_skip;
            s1_mode <= active_mode;
        end
    end

    assign s1_r = s1_rgb[W-1 -: COLOR_BITS];
    assign s1_g = s1_rgb[2*COLOR_BITS-1 -: COLOR_BITS];
    assign s1_b = s1_rgb[COLOR_BITS-1:0];

    // Weights sum to 256, so the accumulator never exceeds 256*max.
    assign luma_acc = ACC'(s1_r) * ACC'(77) + ACC'(s1_g) * ACC'(150) + ACC'(s1_b) * ACC'(29);
    assign luma     = luma_acc[ACC-1:8];

    always_comb begin
        s2_next = s1_rgb;
        case (s1_mode)
            MODE_GRAY:   s2_next = {luma, luma, luma};
            MODE_INVERT: s2_next = ~s1_rgb;
`ifdef DISPLAY_MODE_DIM_EN
            MODE_DIM:    s2_next = {1'b0, s1_r[COLOR_BITS-1:1],
                                    1'b0, s1_g[COLOR_BITS-1:1],
                                    1'b0, s1_b[COLOR_BITS-1:1]};
`endif
            default:     s2_next = s1_rgb;
        endcase
        if (!s1_de) begin
            s2_next = '0;
        end
    end

    // Stage 2: registered result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vout_rgb  <= '0;
            vout_vs   <= 1'b0;
            vout_hs   <= 1'b0;
            vout_de   <= 1'b0;
            vout_skip <= 1'b0;
        end else begin
            vout_rgb  <= s2_next;
            vout_vs   <= s1_vs;
            vout_hs   <= s1_hs;
            vout_de   <= s1_de;
            vout_skip <= s1_skip;
        end
    end

endmodule

// File: tb/tb_video_display_mode_filter.sv
// tb/tb_video_display_mode_filter.sv - self-checking bench for video_display_mode_filter
module tb_video_display_mode_filter;

    logic        clk;
    logic        reset;
    logic        notify_valid;
    logic [1:0]  notify_mode;
    logic        notify_done;
    logic [1:0]  affirm_mode;
    logic [1:0]  active_mode;
    logic [23:0] vin_rgb;
    logic        vin_vs, vin_hs, vin_de, vin_skip;
    logic [23:0] vout_rgb;
    logic        vout_vs, vout_hs, vout_de, vout_skip;

    int tests = 0;
    int fails = 0;

    video_display_mode_filter #(
        .COLOR_BITS(8), .SUPPORTS_GRAYSCALE(1), .SUPPORTS_INVERT(1)
    ) dut (
        .clk(clk), .reset(reset),
        .notify_valid(notify_valid), .notify_mode(notify_mode),
        .notify_done(notify_done), .affirm_mode(affirm_mode), .active_mode(active_mode),
        .vin_rgb(vin_rgb), .vin_vs(vin_vs), .vin_hs(vin_hs), .vin_de(vin_de), .vin_skip(vin_skip),
        .vout_rgb(vout_rgb), .vout_vs(vout_vs), .vout_hs(vout_hs), .vout_de(vout_de),
        .vout_skip(vout_skip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DISPLAY_MODE_DIM_EN
    localparam logic [1:0] DIM_RESULT = 2'd3;
`else
    localparam logic [1:0] DIM_RESULT = 2'd0;
`endif

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] model_resolve(input logic [1:0] m);
        if (m == 2'd3) return DIM_RESULT;
        return m;
    endfunction

    function automatic logic [23:0] model_pixel(input logic [23:0] px, input logic de,
                                                input logic [1:0] m);
        int r, g, b, y;
        r = int'(px[23:16]);
        g = int'(px[15:8]);
        b = int'(px[7:0]);
        if (!de) return 24'h0;
        case (m)
            2'd1: begin
                y = (77 * r + 150 * g + 29 * b) / 256;
                r = y; g = y; b = y;
            end
            2'd2: begin r = 255 - r; g = 255 - g; b = 255 - b; end
            2'd3: begin r = r / 2; g = g / 2; b = b / 2; end
            default: ;
        endcase
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // Model state: mode the host asked for, mode of the current frame, and
    // the pixel stream as it must appear two cycles later.
    logic [1:0]  m_requested, m_frame_mode;
    logic        m_last_vs;
    logic        e_done;
    logic [1:0]  e_aff;
    logic [27:0] e_hist [2];   // {rgb, vs, hs, de, skip}

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_requested  <= 2'd0;
            m_frame_mode <= 2'd0;
            m_last_vs    <= 1'b0;
            e_done       <= 1'b0;
            e_aff        <= 2'd0;
            e_hist[0]    <= '0;
            e_hist[1]    <= '0;
        end else begin
            e_hist[0] <= {model_pixel(vin_rgb, vin_de, m_frame_mode), vin_vs, vin_hs, vin_de, vin_skip};
            e_hist[1] <= e_hist[0];
            e_done    <= notify_valid;
            if (notify_valid) begin
                e_aff       <= model_resolve(notify_mode);
                m_requested <= model_resolve(notify_mode);
            end
            if (vin_vs && !m_last_vs) m_frame_mode <= m_requested;
            m_last_vs <= vin_vs;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        chk("cycle", {31'd0, vout_rgb, vout_vs, vout_hs, vout_de, vout_skip,
                      notify_done, affirm_mode, active_mode},
                     {31'd0, e_hist[1], e_done, e_aff, m_frame_mode});
    endtask

    task automatic pix(input string name, input logic [23:0] px, input logic de,
                       input logic [23:0] exp);
        tick();
        vin_rgb = px; vin_de = de;
        tick();
        vin_rgb = 24'h0; vin_de = 1'b0;
        tick();
        chk(name, {40'd0, vout_rgb}, {40'd0, exp});
    endtask

    task automatic request(input string name, input logic [1:0] m, input logic [1:0] exp_aff);
        tick();
        notify_valid = 1'b1; notify_mode = m;
        tick();
        notify_valid = 1'b0; notify_mode = 2'd0;
        chk({name, "_done"}, {63'd0, notify_done}, 64'd1);
        chk({name, "_aff"}, {62'd0, affirm_mode}, {62'd0, exp_aff});
        tick();
        chk({name, "_done_low"}, {63'd0, notify_done}, 64'd0);
    endtask

    task automatic vs_pulse();
        tick();
        vin_vs = 1'b1;
        tick();
        vin_vs = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        notify_valid = 1'b0; notify_mode = 2'd0;
        vin_rgb = 24'h0; vin_vs = 1'b0; vin_hs = 1'b0; vin_de = 1'b0; vin_skip = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {31'd0, vout_rgb, vout_vs, vout_hs, vout_de, vout_skip,
                              notify_done, affirm_mode, active_mode}, 64'd0);
        reset = 1'b0;

        // Passthrough with controls delayed by exactly two cycles.
        tick();
        vin_rgb = 24'hFF8040; vin_de = 1'b1; vin_hs = 1'b1; vin_skip = 1'b1;
        tick();
        vin_rgb = 24'h0; vin_de = 1'b0; vin_hs = 1'b0; vin_skip = 1'b0;
        chk("latency_not_1", {60'd0, vout_hs, vout_de, vout_skip, 1'b0}, 64'd0);
        tick();
        chk("pass_rgb", {40'd0, vout_rgb}, 64'hFF8040);
        chk("pass_ctrl", {61'd0, vout_hs, vout_de, vout_skip}, 64'd7);
        tick();
        vin_vs = 1'b1;
        tick();
        vin_vs = 1'b0;
        tick();
        chk("vs_delay", {63'd0, vout_vs}, 64'd1);

        // Grayscale requested mid-frame; applied only after the vs rise.
        request("req_gray", 2'd1, 2'd1);
        pix("gray_before_vs", 24'hFF8040, 1'b1, 24'hFF8040);
        vs_pulse();
        chk("active_gray", {62'd0, active_mode}, 64'd1);
        pix("gray_pixel", 24'hFF8040, 1'b1, 24'h9E9E9E);

        // Invert, including de = 0 blanking.
        request("req_inv", 2'd2, 2'd2);
        vs_pulse();
        pix("inv_pixel", 24'h102030, 1'b1, 24'hEFDFCF);
        pix("inv_de0", 24'h102030, 1'b0, 24'h000000);

        // Dim: optional.
        request("req_dim", 2'd3, DIM_RESULT);
        vs_pulse();
`ifdef DISPLAY_MODE_DIM_EN
        pix("dim_pixel", 24'hFF8040, 1'b1, 24'h7F4020);
`else
        pix("dim_pixel", 24'hFF8040, 1'b1, 24'hFF8040);
`endif

        // Back-to-back requests: last one wins.
        tick();
        notify_valid = 1'b1; notify_mode = 2'd1;
        tick();
        notify_mode = 2'd2;
        chk("b2b_done1", {63'd0, notify_done}, 64'd1);
        tick();
        notify_valid = 1'b0; notify_mode = 2'd0;
        chk("b2b_done2", {63'd0, notify_done}, 64'd1);
        chk("b2b_aff", {62'd0, affirm_mode}, 64'd2);
        vs_pulse();
        chk("b2b_active", {62'd0, active_mode}, 64'd2);

        // Request coincident with vs rise waits a frame.
        request("req_norm", 2'd0, 2'd0);
        tick();
        notify_valid = 1'b1; notify_mode = 2'd1; vin_vs = 1'b1;
        tick();
        notify_valid = 1'b0; notify_mode = 2'd0; vin_vs = 1'b0;
        chk("coinc_old_applied", {62'd0, active_mode}, 64'd0);
        vs_pulse();
        chk("coinc_next_frame", {62'd0, active_mode}, 64'd1);

        // Reset mid-frame while in grayscale.
        tick();
        vin_rgb = 24'hFF8040; vin_de = 1'b1; vin_hs = 1'b1;
        tick();
        tick();
        chk("pre_reset_gray", {40'd0, vout_rgb}, 64'h9E9E9E);
        #2 reset = 1'b1;
        #1;
        chk("reset_immediate", {31'd0, vout_rgb, vout_vs, vout_hs, vout_de, vout_skip,
                                notify_done, affirm_mode, active_mode}, 64'd0);
        vin_rgb = 24'h0; vin_de = 1'b0; vin_hs = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        vs_pulse();
        chk("post_reset_mode", {62'd0, active_mode}, 64'd0);
        pix("post_reset_pixel", 24'hFF8040, 1'b1, 24'hFF8040);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
